// File: rtl/mux2x4_arbiter.sv
// Round-robin owner sequencer for the shared quad 2:1 bus mux.
// Holds the mux disabled for a settle gap before every ownership change.
module mux2x4_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       g,
  output logic       busy
);

  localparam int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int SETTLE_W = (SETTLE_CYCLES <= 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = (MAX_HOLD == 0) ? HOLD_W'(0) : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OWN    = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                last_owner_r, last_owner_s;
  logic [SETTLE_W-1:0] settle_cnt_r, settle_cnt_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic                sel_s;
  logic                g_s;
  logic                busy_s;
  logic [1:0]          gnt_s;
  logic                other_s;
  logic                preempt_s;

  // Sole requester wins; on a tie the one that did not own the bus last wins.
  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    logic w;
    case (r)
      2'b01:   w = 1'b0;
      2'b10:   w = 1'b1;
      default: w = ~last;
    endcase
    return w;
  endfunction

  assign other_s   = ~sel;
  // Counter only ever rests at MAX_HOLD-1 or MAX_HOLD once the hold limit is reached.
  assign preempt_s = (MAX_HOLD != 0) && req[other_s] &&
                     ((hold_cnt_r == HOLD_LAST) || (hold_cnt_r == HOLD_MAX));

  // Next-state and counter update.
  always_comb begin
    state_s      = state_r;
    sel_s        = sel;
    last_owner_s = last_owner_r;
    settle_cnt_s = settle_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_s      = ST_SETTLE;
          sel_s        = pick_winner(req, last_owner_r);
          settle_cnt_s = SETTLE_INIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!req[sel]) begin
          state_s = ST_IDLE;
        end else if (settle_cnt_r == SETTLE_W'(0)) begin
          state_s    = ST_OWN;
          hold_cnt_s = HOLD_W'(0);
        end else begin
          settle_cnt_s = settle_cnt_r - SETTLE_W'(1);
        end
      end
      ST_OWN: begin
        if (!req[sel] || preempt_s) begin
          last_owner_s = sel;
          if (req[other_s]) begin
            state_s      = ST_SETTLE;
            sel_s        = other_s;
            settle_cnt_s = SETTLE_INIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (hold_cnt_r != HOLD_MAX) begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Mux controls follow the next state so they register together with it.
  always_comb begin
    gnt_s  = 2'b00;
    g_s    = 1'b1;
    busy_s = (state_s != ST_IDLE);
    if (state_s == ST_OWN) begin
      g_s   = 1'b0;
      gnt_s = sel_s ? 2'b10 : 2'b01;
    end else begin
      g_s   = 1'b1;
      gnt_s = 2'b00;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sel          <= 1'b0;
      g            <= 1'b1;
      gnt          <= 2'b00;
      busy         <= 1'b0;
      last_owner_r <= 1'b1;
      settle_cnt_r <= SETTLE_W'(0);
      hold_cnt_r   <= HOLD_W'(0);
    end else begin
      state_r      <= state_s;
      sel          <= sel_s;
      g            <= g_s;
      gnt          <= gnt_s;
      busy         <= busy_s;
      last_owner_r <= last_owner_s;
      settle_cnt_r <= settle_cnt_s;
      hold_cnt_r   <= hold_cnt_s;
    end
  end

endmodule

// File: tb/tb_mux2x4_arbiter.sv
// Scoreboard bench: dut_a has MAX_HOLD=4, dut_b has preemption disabled.
module tb_mux2x4_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_a, req_b;
  logic [1:0] gnt_a, gnt_b;
  logic       sel_a, sel_b, g_a, g_b, busy_a, busy_b;
  logic       prev_sel_a, prev_sel_b;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    logic       on_b;
    int         idx;
    logic [1:0] gnt;
    logic       sel;
    logic       g;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  mux2x4_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .sel(sel_a), .g(g_a), .busy(busy_a)
  );

  mux2x4_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b), .g(g_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] eg,
                      input logic es, input logic eg1, input logic eb, input logic on_b);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (on_b) begin
      req_b = rq;
      req_a = 2'b00;
    end else begin
      req_a = rq;
      req_b = 2'b00;
    end
    step_no++;
    e.on_b = on_b; e.idx = step_no; e.gnt = eg; e.sel = es; e.g = eg1; e.busy = eb;
    sb_q.push_back(e);
  endtask

  task automatic inv_check(input string nm, input logic [1:0] gn, input logic s,
                           input logic gg, input logic ps);
    checks++;
    if (!$onehot0(gn) || ((gn != 2'b00) != (gg == 1'b0)) ||
        ((gn != 2'b00) && (gn[s] !== 1'b1)) || ((gg == 1'b0) && (s !== ps))) begin
      errors++;
      $display("FAIL invariant_%s t=%0t: gnt=%b sel=%b g=%b prev_sel=%b", nm, $time, gn, s, gg, ps);
    end
  endtask

  // Monitor: compare each queued expectation just after the edge it describes.
  always @(posedge clk) begin
    exp_t e;
    #1;
    inv_check("a", gnt_a, sel_a, g_a, prev_sel_a);
    inv_check("b", gnt_b, sel_b, g_b, prev_sel_b);
    prev_sel_a = sel_a;
    prev_sel_b = sel_b;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (e.on_b) begin
        if (gnt_b !== e.gnt || sel_b !== e.sel || g_b !== e.g || busy_b !== e.busy) begin
          errors++;
          $display("FAIL dut_b step %0d: got gnt=%b sel=%b g=%b busy=%b, expected gnt=%b sel=%b g=%b busy=%b",
                   e.idx, gnt_b, sel_b, g_b, busy_b, e.gnt, e.sel, e.g, e.busy);
        end
      end else begin
        if (gnt_a !== e.gnt || sel_a !== e.sel || g_a !== e.g || busy_a !== e.busy) begin
          errors++;
          $display("FAIL dut_a step %0d: got gnt=%b sel=%b g=%b busy=%b, expected gnt=%b sel=%b g=%b busy=%b",
                   e.idx, gnt_a, sel_a, g_a, busy_a, e.gnt, e.sel, e.g, e.busy);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_a = 2'b00;
    req_b = 2'b00;
    prev_sel_a = 1'b0;
    prev_sel_b = 1'b0;

    // Reset with both requesting, then requester 0 wins the first tie.
    step(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    // Round-robin hand-over to requester 1 on release.
    step(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    // Tie after requester 1 owned: requester 0 wins.
    step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    // Preemption: req[1] rises while owned, owner cut off after 4 owned cycles.
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    // Reset mid-OWN.
    step(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    // Single request latency and release.
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    // Abort in SETTLE, including when only the non-selected requester remains.
    step(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    // MAX_HOLD=0: owner keeps the bus for 50 cycles despite a waiting requester.
    step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
